bomb_square_object: RTL

- Upstream stage of the bomb bitmap. Owns one bomb's lifecycle: placement on the 32-px grid, frame-counted fuse, blink warning, explosion window.
- Per pixel, produces the registered offsetX/offsetY/InsideRectangle triple consumed by the bitmap.
- Produces status and a one-shot explode pulse for the game controller and the explosion drawer.

---
 rtl/bomb_square_object.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bomb_square_object.sv
// Single bomb lifecycle (place, fuse, blink, explode) plus the registered
// per-pixel hit test feeding the bomb bitmap.
module bomb_square_object #(
    parameter int OBJECT_WIDTH   = 32,
    parameter int OBJECT_HEIGHT  = 32,
    parameter int GRID_BITS      = 5,
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int FUSE_FRAMES    = 120,
    parameter int BLINK_FRAMES   = 30,
    parameter int BLINK_BIT      = 2,
    parameter int EXPLODE_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        placeReq,
    input  logic [10:0] playerX,
    input  logic [10:0] playerY,
    input  logic        detonateReq,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        bombActive,
    output logic        exploding,
    output logic        explodePulse
);

    localparam int CNT_MAX = (FUSE_FRAMES > EXPLODE_FRAMES) ? FUSE_FRAMES : EXPLODE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [11:0] GRID_MASK = ~(12'((1 << GRID_BITS) - 1));
    localparam logic [11:0] HALF_W    = 12'(OBJECT_WIDTH / 2);
    localparam logic [11:0] HALF_H    = 12'(OBJECT_HEIGHT / 2);
    localparam logic [11:0] MAX_X     = 12'(SCREEN_WIDTH - OBJECT_WIDTH);
    localparam logic [11:0] MAX_Y     = 12'(SCREEN_HEIGHT - OBJECT_HEIGHT);
    localparam logic [11:0] OBJ_W12   = 12'(OBJECT_WIDTH);
    localparam logic [11:0] OBJ_H12   = 12'(OBJECT_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_EXPLODING = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [10:0]      tlx_r, tlx_s, tly_r, tly_s;
    logic             pulse_r, pulse_s;
    logic             inside_r;
    logic [10:0]      offx_r, offy_r;

    logic             inside_s, visible_s, fuse_done_s;
    logic [11:0]      px12_s, py12_s, tlx12_s, tly12_s;

    // Centre the bomb under the player, snap to the grid, keep it on screen.
    function automatic logic [10:0] snap_pos(input logic [10:0] p, input logic [11:0] half,
                                             input logic [11:0] lim);
        logic [11:0] s;
        s = ({1'b0, p} + half) & GRID_MASK;
        if (s > lim) begin
            s = lim;
        end else begin
            s = s;
        end
        return s[10:0];
    endfunction

    // Lifecycle next-state: placement, fuse countdown, detonation, explosion window.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        tlx_s       = tlx_r;
        tly_s       = tly_r;
        pulse_s     = 1'b0;
        fuse_done_s = startOfFrame && (cnt_r == CNT_W'(1));
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (placeReq) begin
                    state_s = ST_ARMED;
                    cnt_s   = CNT_W'(FUSE_FRAMES);
                    tlx_s   = snap_pos(playerX, HALF_W, MAX_X);
                    tly_s   = snap_pos(playerY, HALF_H, MAX_Y);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Chain detonation and fuse expiry collapse into one transition/pulse.
                if (detonateReq || fuse_done_s) begin
                    state_s = ST_EXPLODING;
                    cnt_s   = CNT_W'(EXPLODE_FRAMES);
                    pulse_s = 1'b1;
                end else if (startOfFrame) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_EXPLODING: begin
                if (fuse_done_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (startOfFrame) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Hit test against the latched position, with blink gating near the end of the fuse.
    always_comb begin
        px12_s    = {1'b0, pixelX};
        py12_s    = {1'b0, pixelY};
        tlx12_s   = {1'b0, tlx_r};
        tly12_s   = {1'b0, tly_r};
        inside_s  = (px12_s >= tlx12_s) && (px12_s < tlx12_s + OBJ_W12) &&
                    (py12_s >= tly12_s) && (py12_s < tly12_s + OBJ_H12);
        visible_s = (state_r == ST_ARMED) &&
                    ((cnt_r > CNT_W'(BLINK_FRAMES)) || !cnt_r[BLINK_BIT]);
    end

    // State, counter, position and per-pixel output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            tlx_r    <= 11'd0;
            tly_r    <= 11'd0;
            pulse_r  <= 1'b0;
            inside_r <= 1'b0;
            offx_r   <= 11'd0;
            offy_r   <= 11'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            tlx_r    <= tlx_s;
            tly_r    <= tly_s;
            pulse_r  <= pulse_s;
            inside_r <= inside_s && visible_s;
            offx_r   <= inside_s ? (pixelX - tlx_r) : 11'd0;
            offy_r   <= inside_s ? (pixelY - tly_r) : 11'd0;
        end
    end

    assign offsetX         = offx_r;
    assign offsetY         = offy_r;
    assign InsideRectangle = inside_r;
    assign topLeftX        = tlx_r;
    assign topLeftY        = tly_r;
    assign bombActive      = (state_r == ST_ARMED);
    assign exploding       = (state_r == ST_EXPLODING);
    assign explodePulse    = pulse_r;

endmodule
